// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU controller: opcode and FSM state
// enums, opcode width and a divide-class helper.
package alu_share_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpMul  = 4'd2,
        OpDiv  = 4'd3,
        OpMod  = 4'd4,
        OpAnd  = 4'd5,
        OpOr   = 4'd6,
        OpXor  = 4'd7,
        OpXnor = 4'd8,
        OpNot  = 4'd9,
        OpShl  = 4'd10,
        OpShr  = 4'd11,
        OpAsr  = 4'd12,
        OpRed  = 4'd13,
        OpCmp  = 4'd14,
        OpCat  = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDiv,
        StResp
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return (op == OpDiv) || (op == OpMod);
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider, one quotient bit per clock, WIDTH clocks.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (aborts a run)
//   start_i            load dividend/divisor and begin (ignored result of old run)
//   dividend_i, divisor_i  operands; divisor must be non-zero
//   busy_o             a division is in progress
//   done_o             high in the final iteration cycle; quot_o/rem_o valid then
//   quot_o, rem_o      quotient and remainder produced by the final iteration
module alu_div_iter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic             busy_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] div_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // rem < divisor always holds, so shifted < 2*divisor and the difference
    // fits in WIDTH+1 signed bits: its MSB is the "does not fit" flag.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, div_q};
        fits     = ~diff[WIDTH];
        rem_step = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fits};
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CntW'(WIDTH - 1));
    assign quot_o = quo_step;
    assign rem_o  = rem_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend_i;
            div_q  <= divisor_i;
        end else if (busy_q) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shared-ALU controller: round-robin arbitration between NREQ requesters,
// single-cycle operators plus an iterative divider, registered tagged result
// over a valid/ready handshake.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot or zero)
//   req_op/req_a/req_b    packed per-requester opcode and operands
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                index of the requester that owns the result
//   rsp_data              2*WIDTH-bit result
//   rsp_err               divide or modulo by zero
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [OP_W*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0]    req_a,
    input  logic [WIDTH*NREQ-1:0]    req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [2*WIDTH-1:0]       rsp_data,
    output logic                     rsp_err
);

    localparam int unsigned IdW = $clog2(NREQ);
    localparam int unsigned RW  = 2 * WIDTH;

    function automatic logic [RW-1:0] zext(input logic [WIDTH-1:0] x);
        return {{WIDTH{1'b0}}, x};
    endfunction

    state_e           state_q, state_d;
    logic [IdW-1:0]   last_q, last_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IdW-1:0]   id_q, id_d;
    logic [RW-1:0]    data_q, data_d;
    logic             err_q, err_d;

    // Round-robin arbiter: first valid requester after the last grant.
    logic           grant_vld;
    logic [IdW-1:0] grant_id;
    logic [IdW-1:0] cand;
    logic           handshake;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IdW'((32'(last_q) + i) % NREQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign handshake = (state_q == StIdle) && grant_vld && !rst;

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    op_e              op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             sel_div;

    assign op_sel  = op_e'(req_op[32'(grant_id)*OP_W +: OP_W]);
    assign a_sel   = req_a[32'(grant_id)*WIDTH +: WIDTH];
    assign b_sel   = req_b[32'(grant_id)*WIDTH +: WIDTH];
    assign sel_div = is_div_op(op_sel) && (b_sel != '0);

    // Divider
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    alu_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (a_sel),
        .divisor_i  (b_sel),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Single-cycle operators on the latched request. DIV/MOD only reach this
    // path with a zero divisor.
    logic [RW-1:0]           alu_res;
    logic                    alu_err;
    logic [WIDTH:0]          add_w;
    logic [WIDTH:0]          sub_w;
    logic [RW-1:0]           mul_w;
    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH-1:0]        asr_w;
    logic                    big_sh;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        sub_w   = {1'b0, a_q} - {1'b0, b_q};   // bit WIDTH is the borrow
        mul_w   = zext(a_q) * zext(b_q);
        a_s     = a_q;
        asr_w   = a_s >>> b_q;
        big_sh  = 32'(b_q) >= WIDTH;
        case (op_q)
            OpAdd:  alu_res = RW'(add_w);
            OpSub:  alu_res = RW'(sub_w);
            OpMul:  alu_res = mul_w;
            OpDiv: begin
                alu_res = {a_q, {WIDTH{1'b1}}};
                alu_err = 1'b1;
            end
            OpMod: begin
                alu_res = zext(a_q);
                alu_err = 1'b1;
            end
            OpAnd:  alu_res = zext(a_q & b_q);
            OpOr:   alu_res = zext(a_q | b_q);
            OpXor:  alu_res = zext(a_q ^ b_q);
            OpXnor: alu_res = zext(~(a_q ^ b_q));
            OpNot:  alu_res = zext(~a_q);
            OpShl:  alu_res = big_sh ? '0 : zext(a_q << b_q);
            OpShr:  alu_res = big_sh ? '0 : zext(a_q >> b_q);
            OpAsr:  alu_res = big_sh ? zext({WIDTH{a_q[WIDTH-1]}}) : zext(asr_w);
            OpRed: begin
                alu_res[0] = &a_q;
                alu_res[1] = |a_q;
                alu_res[2] = ^a_q;
            end
            OpCmp: begin
                alu_res[0] = a_q == b_q;
                alu_res[1] = a_q < b_q;
                alu_res[2] = a_q > b_q;
            end
            OpCat:  alu_res = {a_q, b_q};
        endcase
    end

    // Controller FSM
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        data_d    = data_q;
        err_d     = err_q;
        div_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    op_d   = op_sel;
                    a_d    = a_sel;
                    b_d    = b_sel;
                    id_d   = grant_id;
                    last_d = grant_id;
                    if (sel_div) begin
                        state_d = StDiv;
                        // Divider is always idle here; the gate only keeps a
                        // stray start from clobbering a run in progress.
                        div_start = !div_busy;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                data_d  = alu_res;
                err_d   = alu_err;
                state_d = StResp;
            end
            StDiv: begin
                if (div_done) begin
                    data_d  = (op_q == OpDiv) ? {div_rem, div_quot} : zext(div_rem);
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= IdW'(NREQ - 1);
            op_q    <= OpAdd;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl (WIDTH=4, NREQ=2): expected responses are
// queued at each request handshake and compared when rsp_valid appears.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned N = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [0:0]     rsp_id;
    logic [2*W-1:0] rsp_data;
    logic           rsp_err;

    alu_share_ctrl #(
        .WIDTH (W),
        .NREQ  (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0] id;
        logic [7:0] data;
        logic       err;
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b);
        req_valid[id]      = 1'b1;
        req_op[id*4 +: 4]  = op;
        req_a[id*4 +: 4]   = a;
        req_b[id*4 +: 4]   = b;
    endtask

    // Drive one request, wait (bounded) for its grant, queue the expectation.
    task automatic issue(input int id, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] data, input logic err,
                         input int lat);
        bit           ok;
        logic [N-1:0] oh;
        @(negedge clk);
        set_req(id, op, a, b);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        oh     = '0;
        oh[id] = 1'b1;
        chk("grant", 32'(req_ready), 32'(oh));
        if (ok) begin
            sb.push_back('{1'(id), data, err, 8'(lat)});
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
    endtask

    // Wait (bounded) for a response, compare against the queue head.
    // Latency counts clock edges after the request handshake edge.
    task automatic expect_rsp();
        int   lat;
        exp_t e;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("latency", 32'(lat), 32'(e.lat));
            if (rsp_ready) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run(input int id, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] data, input logic err,
                       input int lat);
        issue(id, op, a, b, data, err, lat);
        expect_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           ok;
        bit           seen;
        logic [N-1:0] oh;

        // Reset state, with requests pending to show ready is held low.
        set_req(0, OpAdd, 4'd1, 4'd1);
        set_req(1, OpAdd, 4'd1, 4'd1);
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        run(0, OpAdd, 4'd9, 4'd8, 8'h11, 1'b0, 1);
        run(1, OpDiv, 4'd13, 4'd4, 8'h13, 1'b0, 4);
        run(1, OpMod, 4'd13, 4'd4, 8'h01, 1'b0, 4);

        // Both requesters valid continuously: grants must alternate 0,1,0,1.
        @(negedge clk);
        set_req(0, OpSub, 4'd3, 4'd5);
        set_req(1, OpMul, 4'd5, 4'd7);
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            ok = 1'b0;
            for (int n = 0; n < 20; n++) begin
                #1;
                if (|req_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("rr_grant", 32'(req_ready), 32'(oh));
            if (ok) begin
                if (k % 2 == 0) sb.push_back('{1'b0, 8'h1E, 1'b0, 8'd1});
                else            sb.push_back('{1'b1, 8'h23, 1'b0, 8'd1});
                @(posedge clk);
                #1;
            end
            expect_rsp();
        end
        req_valid = '0;

        // Zero divisor takes the single-cycle path and flags an error.
        run(0, OpDiv, 4'd5, 4'd0, 8'h5F, 1'b1, 1);
        run(0, OpMod, 4'd5, 4'd0, 8'h05, 1'b1, 1);

        // Operator sweep, alternating requesters.
        run(1, OpSub, 4'd5, 4'd3, 8'h02, 1'b0, 1);
        run(0, OpAdd, 4'hF, 4'hF, 8'h1E, 1'b0, 1);
        run(1, OpMul, 4'hF, 4'hF, 8'hE1, 1'b0, 1);
        run(0, OpDiv, 4'hF, 4'd1, 8'h0F, 1'b0, 4);
        run(1, OpDiv, 4'd7, 4'd3, 8'h12, 1'b0, 4);
        run(0, OpMod, 4'd14, 4'd5, 8'h04, 1'b0, 4);
        run(1, OpAnd, 4'hC, 4'hA, 8'h08, 1'b0, 1);
        run(0, OpOr, 4'hC, 4'hA, 8'h0E, 1'b0, 1);
        run(1, OpXor, 4'hC, 4'hA, 8'h06, 1'b0, 1);
        run(0, OpXnor, 4'hC, 4'hA, 8'h09, 1'b0, 1);
        run(1, OpNot, 4'h5, 4'h0, 8'h0A, 1'b0, 1);
        run(0, OpShl, 4'h3, 4'd2, 8'h0C, 1'b0, 1);
        run(1, OpShl, 4'h1, 4'd4, 8'h00, 1'b0, 1);
        run(0, OpShr, 4'hC, 4'd2, 8'h03, 1'b0, 1);
        run(1, OpShr, 4'hC, 4'd5, 8'h00, 1'b0, 1);
        run(0, OpAsr, 4'h9, 4'd1, 8'h0C, 1'b0, 1);
        run(1, OpAsr, 4'h9, 4'd7, 8'h0F, 1'b0, 1);
        run(0, OpAsr, 4'h6, 4'd1, 8'h03, 1'b0, 1);
        run(1, OpRed, 4'h7, 4'h0, 8'h06, 1'b0, 1);
        run(0, OpRed, 4'hF, 4'h0, 8'h03, 1'b0, 1);
        run(1, OpCmp, 4'd3, 4'd5, 8'h02, 1'b0, 1);
        run(0, OpCmp, 4'd5, 4'd5, 8'h01, 1'b0, 1);
        run(1, OpCmp, 4'd9, 4'd2, 8'h04, 1'b0, 1);
        run(0, OpCat, 4'h3, 4'hC, 8'h3C, 1'b0, 1);

        // Backpressure: result held while a second request waits ungranted.
        rsp_ready = 1'b0;
        issue(1, OpCat, 4'hA, 4'h5, 8'hA5, 1'b0, 1);
        set_req(0, OpNot, 4'h5, 4'h0);
        expect_rsp();
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'hA5);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b01);
        run(0, OpNot, 4'h5, 4'h0, 8'h0A, 1'b0, 1);

        // Reset while a result is presented drops it without a clock edge.
        rsp_ready = 1'b0;
        issue(0, OpAdd, 4'd1, 4'd1, 8'h02, 1'b0, 1);
        expect_rsp();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Reset during the 2nd divide cycle aborts the op with no response.
        issue(0, OpDiv, 4'd13, 4'd4, 8'h13, 1'b0, 4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        set_req(0, OpAdd, 4'd1, 4'd2);
        set_req(1, OpAdd, 4'd3, 4'd4);
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b01);
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
